// File: rtl/neg_arbiter_pkg.sv
// Shared definitions for the two-requester negation arbiter: FSM encoding and default width.
package neg_arbiter_pkg;

    localparam int NEG_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/neg_arbiter_neg_unit.sv
// Combinational two's-complement negation, modulo 2^WIDTH.
module neg_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = ~in_i + WIDTH'(1);

endmodule

// File: rtl/neg_arbiter.sv
// Round-robin arbiter sharing one negation unit between two requesters, one op in flight.
// Optional overflow flag output (most-negative operand) enabled by NEG_OVF_FLAG_EN.
module neg_arbiter
    import neg_arbiter_pkg::*;
#(
    parameter int WIDTH = NEG_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
`ifdef NEG_OVF_FLAG_EN
    output logic             rsp_ovf,
`endif
    output logic             busy
);

    state_e           state_q;
    logic             last_q;
    logic [WIDTH-1:0] op_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             busy_q;

    logic             gnt0, gnt1;
    logic             acc0, acc1;
    logic [WIDTH-1:0] neg_w;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt0 = req0_valid && (!req1_valid || last_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_q);

    // Readies are forced low while reset is asserted so no handshake is seen then.
    assign req0_ready = rst_n && (state_q == S_IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == S_IDLE) && gnt1;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;

    neg_unit #(.WIDTH(WIDTH)) u_neg (
        .in_i  (op_q),
        .out_o (neg_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc0 || acc1) begin
                        op_q    <= acc1 ? req1_data : req0_data;
                        id_q    <= acc1;
                        last_q  <= acc1;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= neg_w;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NEG_OVF_FLAG_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state_q == S_EXEC)
            ovf_q <= (op_q == MOST_NEG);
    end

    assign rsp_ovf = ovf_q;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule
